// File: rtl/pic_params.sv
// Shared constants for the baseline 12-bit PIC core: ALU opcode width and
// the opcode codes driven from the sequencer to the ALU.
package pic_params;

    localparam int ALU_INST_WIDTH = 5;

    // Codes are assigned in the same order as the decode groups.
    localparam logic [ALU_INST_WIDTH-1:0] ALU_NOP    = 5'd0;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_MOVWF  = 5'd1;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_CLRW   = 5'd2;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_CLRF   = 5'd3;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_SUBWF  = 5'd4;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_DECF   = 5'd5;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_IORWF  = 5'd6;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_ANDWF  = 5'd7;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_XORWF  = 5'd8;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_ADDWF  = 5'd9;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_MOVF   = 5'd10;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_COMF   = 5'd11;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_INCF   = 5'd12;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_DECFSZ = 5'd13;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_RRF    = 5'd14;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_RLF    = 5'd15;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_SWAPF  = 5'd16;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_INCFSZ = 5'd17;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_BCF    = 5'd18;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_BSF    = 5'd19;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_BTFSC  = 5'd20;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_BTFSS  = 5'd21;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_MOVLW  = 5'd22;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_IORLW  = 5'd23;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_ANDLW  = 5'd24;
    localparam logic [ALU_INST_WIDTH-1:0] ALU_XORLW  = 5'd25;

endpackage

// File: rtl/pic_sequencer.sv
// pic_sequencer: fetch/decode/execute controller for the baseline 12-bit PIC.
// Fetches from program ROM, decodes into ALU controls, and executes all
// program-flow instructions with a PC and a 2-level hardware stack.
// Optional feature macro: PIC_STACK_CHECK_EN (sticky stack over/underflow flag).
module pic_sequencer #(
    parameter int                    DWIDTH         = 8,
    parameter int                    IWIDTH         = 12,
    parameter int                    PC_WIDTH       = 9,
    parameter int                    ALU_INST_WIDTH = pic_params::ALU_INST_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR   = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      wake,
    output logic [PC_WIDTH-1:0]       pmem_addr,
    output logic                      pmem_rd,
    input  logic [IWIDTH-1:0]         pmem_data,
    output logic [ALU_INST_WIDTH-1:0] alu_instruction,
    output logic [2:0]                bit_num,
    output logic [DWIDTH-1:0]         literal_value,
    output logic                      dest_bit,
    output logic [4:0]                freg_addr,
    input  logic                      alu_skip,
    output logic                      sleeping,
    output logic                      stack_err
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_SKIP,
        ST_SLEEP
    } state_t;

    localparam logic [IWIDTH-1:0] SLEEP_WORD = IWIDTH'(12'h003);

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [IWIDTH-1:0]   ir;
    logic [PC_WIDTH-1:0] stk0;
    logic [PC_WIDTH-1:0] stk1;
    logic                is_goto;
    logic                is_call;
    logic                is_retlw;
    logic                push;
    logic                pop;

    // Map an instruction word onto the ALU opcode it needs; control-flow and
    // NOP-class words drive NOP, RETLW drives MOVLW so W receives the literal.
    function automatic logic [ALU_INST_WIDTH-1:0] decode_alu(input logic [IWIDTH-1:0] w);
        logic [5:0]                grp;
        logic [ALU_INST_WIDTH-1:0] op;
        grp = w[11:6] - 6'd2;
        op  = pic_params::ALU_NOP;
        casez (w[11:0])
            12'b0000_001?_????: op = pic_params::ALU_MOVWF;
            12'b0000_0100_0000: op = pic_params::ALU_CLRW;
            12'b0000_011?_????: op = pic_params::ALU_CLRF;
            12'b0000_0???_????: op = pic_params::ALU_NOP;
            12'b00??_????_????: op = pic_params::ALU_SUBWF + ALU_INST_WIDTH'(grp);
            12'b01??_????_????: op = pic_params::ALU_BCF + ALU_INST_WIDTH'(w[9:8]);
            12'b1000_????_????: op = pic_params::ALU_MOVLW;
            12'b11??_????_????: op = pic_params::ALU_MOVLW + ALU_INST_WIDTH'(w[9:8]);
            default:            op = pic_params::ALU_NOP;
        endcase
        return op;
    endfunction

    assign is_goto   = (ir[11:9] == 3'b101);
    assign is_call   = (ir[11:8] == 4'b1001);
    assign is_retlw  = (ir[11:8] == 4'b1000);
    assign pmem_addr = pc;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the combinational strobes for ROM, sleep and stack.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        next_state = state;
        pmem_rd    = 1'b0;
        sleeping   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_FETCH: begin
                if (run) begin
                    pmem_rd    = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC: begin
                push       = is_call;
                pop        = is_retlw;
                next_state = ST_WB;
            end
            ST_WB: begin
                if (alu_skip) begin
                    next_state = ST_SKIP;
                end else if (ir == SLEEP_WORD) begin
                    next_state = ST_SLEEP;
                end else begin
                    next_state = ST_FETCH;
                end
            end
            ST_SKIP: next_state = ST_FETCH;
            ST_SLEEP: begin
                sleeping = 1'b1;
                if (wake) begin
                    next_state = ST_FETCH;
                end
            end
            default: next_state = ST_FETCH;
        endcase
    end

    // Datapath: instruction register, registered ALU controls, PC and stack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc              <= RESET_VECTOR;
            ir              <= '0;
            stk0            <= '0;
            stk1            <= '0;
            alu_instruction <= pic_params::ALU_NOP;
            bit_num         <= '0;
            literal_value   <= '0;
            dest_bit        <= 1'b0;
            freg_addr       <= '0;
        end else begin
            case (state)
                ST_DECODE: begin
                    ir              <= pmem_data;
                    pc              <= pc + PC_WIDTH'(1);
                    alu_instruction <= decode_alu(pmem_data);
                    bit_num         <= pmem_data[7:5];
                    literal_value   <= pmem_data[DWIDTH-1:0];
                    dest_bit        <= pmem_data[5];
                    freg_addr       <= pmem_data[4:0];
                end
                ST_EXEC: begin
                    // ALU controls are live only for EXEC; WB sees NOP.
                    alu_instruction <= pic_params::ALU_NOP;
                    if (is_goto) begin
                        pc <= PC_WIDTH'(ir[8:0]);
                    end else if (push) begin
                        stk1 <= stk0;
                        stk0 <= pc;
                        pc   <= PC_WIDTH'(ir[7:0]);
                    end else if (pop) begin
                        // stk1 keeps its value, so a deep pop repeats it.
                        pc   <= stk0;
                        stk0 <= stk1;
                    end
                end
                ST_SKIP: pc <= pc + PC_WIDTH'(1);
                default: ;
            endcase
        end
    end

`ifdef PIC_STACK_CHECK_EN
    logic [1:0] depth;
    logic       err_q;

    // Occupancy tracking with a sticky flag on push-when-full or pop-when-empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth <= 2'd0;
            err_q <= 1'b0;
        end else if (push) begin
            if (depth == 2'd2) begin
                err_q <= 1'b1;
            end else begin
                depth <= depth + 2'd1;
            end
        end else if (pop) begin
            if (depth == 2'd0) begin
                err_q <= 1'b1;
            end else begin
                depth <= depth - 2'd1;
            end
        end
    end

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

endmodule
